// File: rtl/lfsr_prbs_checker.sv
// Receive-side PRBS checker for Galois LFSR generator streams.
// It self-synchronises from the polynomial alone and then runs a flywheel
// prediction. It counts bit errors while locked and drops lock on error bursts.
module lfsr_prbs_checker #(
  parameter int unsigned       Length          = 8,
  parameter logic [Length-1:0] Tap_Coefficient = 8'b1111_0011,
  parameter int unsigned       Lock_Count      = 16,
  parameter int unsigned       Window_Bits     = 32,
  parameter int unsigned       Loss_Errors     = 4,
  parameter int unsigned       Count_Width     = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Bit_In,
  input  logic                   Bit_Valid,
  input  logic                   Clear_Count,
  output logic                   Locked,
  output logic                   Error_Pulse,
  output logic [Count_Width-1:0] Error_Count,
  output logic [Count_Width-1:0] Bit_Count
);

  localparam int unsigned FillW  = $clog2(Length + 1);
  localparam int unsigned MatchW = $clog2(Lock_Count + 1);
  localparam int unsigned WinW   = $clog2(Window_Bits + 1);
  localparam int unsigned BurstW = $clog2(Loss_Errors + 1);

  localparam logic [FillW-1:0]  FillFull  = FillW'(Length);
  localparam logic [MatchW-1:0] MatchFull = MatchW'(Lock_Count);
  localparam logic [WinW-1:0]   WinFull   = WinW'(Window_Bits);
  localparam logic [BurstW-1:0] BurstFull = BurstW'(Loss_Errors);

  // Bit j-1 of the mask weights s[n-j]; the x^0 coefficient is implicit.
  localparam logic [Length-2:0] TapMask = Tap_Coefficient[Length-1:1];

  typedef enum logic {StSearch, StLocked} state_e;

  state_e                   state_q;
  logic [Length-1:0]        hist_q;   // hist_q[j-1] holds s[n-j]
  logic [FillW-1:0]         fill_q;
  logic [MatchW-1:0]        match_q;
  logic [WinW-1:0]          win_q;
  logic [BurstW-1:0]        burst_q;
  logic                     error_pulse_q;
  logic [Count_Width-1:0]   err_cnt_q;
  logic [Count_Width-1:0]   bit_cnt_q;

  logic                     pred;
  logic                     mismatch;
  logic [MatchW-1:0]        match_inc;
  logic [WinW-1:0]          win_inc;
  logic [BurstW-1:0]        burst_nxt;
  logic [Count_Width-1:0]   err_cnt_inc;
  logic [Count_Width-1:0]   bit_cnt_inc;

  // Prediction of the next bit from history, plus saturating/incremented counter values.
  always_comb begin
    pred        = hist_q[Length-1] ^ (^(hist_q[Length-2:0] & TapMask));
    mismatch    = Bit_In ^ pred;
    match_inc   = match_q + 1'b1;
    win_inc     = win_q + 1'b1;
    burst_nxt   = mismatch ? burst_q + 1'b1 : burst_q;
    err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
    bit_cnt_inc = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 1'b1;
  end

  // Sync FSM: history fill and match search, then flywheel with burst-based loss detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= StSearch;
      hist_q        <= '0;
      fill_q        <= '0;
      match_q       <= '0;
      win_q         <= '0;
      burst_q       <= '0;
      error_pulse_q <= 1'b0;
    end else begin
      error_pulse_q <= 1'b0;
      if (Bit_Valid) begin
        unique case (state_q)
          StSearch: begin
            hist_q <= {hist_q[Length-2:0], Bit_In};
            if (fill_q != FillFull) begin
              fill_q <= fill_q + 1'b1;
            end else if (!mismatch && (hist_q != '0)) begin
              match_q <= match_inc;
              if (match_inc == MatchFull) begin
                state_q <= StLocked;
                win_q   <= '0;
                burst_q <= '0;
              end
            end else begin
              match_q <= '0;
            end
          end
          StLocked: begin
            // Flywheel: a channel error never corrupts the local sequence.
            hist_q        <= {hist_q[Length-2:0], pred};
            error_pulse_q <= mismatch;
            if (burst_nxt == BurstFull) begin
              state_q <= StSearch;
              fill_q  <= '0;
              match_q <= '0;
              win_q   <= '0;
              burst_q <= '0;
            end else if (win_inc == WinFull) begin
              win_q   <= '0;
              burst_q <= '0;
            end else begin
              win_q   <= win_inc;
              burst_q <= burst_nxt;
            end
          end
          default: state_q <= StSearch;
        endcase
      end
    end
  end

  // Saturating error and bit counters; a clear wins over a same-cycle increment.
  always_ff @(posedge Clock) begin
    if (Reset || Clear_Count) begin
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (Bit_Valid && (state_q == StLocked)) begin
      bit_cnt_q <= bit_cnt_inc;
      if (mismatch) begin
        err_cnt_q <= err_cnt_inc;
      end
    end
  end

  assign Locked      = (state_q == StLocked);
  assign Error_Pulse = error_pulse_q;
  assign Error_Count = err_cnt_q;
  assign Bit_Count   = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Scoreboard bench for lfsr_prbs_checker: the driver queues expected outputs
// for a bit, and the monitor compares them on the following falling edge.
module tb_lfsr_prbs_checker;

  localparam logic [7:0] TAPS = 8'b1111_0011;
  localparam logic [7:0] SEED = 8'b1001_0001;

  localparam logic [3:0] KLock  = 4'd0;
  localparam logic [3:0] KPNow  = 4'd1;
  localparam logic [3:0] KPTot  = 4'd2;
  localparam logic [3:0] KEcnt  = 4'd3;
  localparam logic [3:0] KBcnt  = 4'd4;
  localparam logic [3:0] KEcnt4 = 4'd5;
  localparam logic [3:0] KBcnt4 = 4'd6;
  localparam logic [3:0] KLock4 = 4'd7;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset, Bit_In, Bit_Valid, Clear_Count;
  logic        locked, pulse, locked4, pulse4;
  logic [15:0] ecnt, bcnt;
  logic [3:0]  ecnt4, bcnt4;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pulse_total = 0;
  logic [7:0]  gh;

  always #5 clk = ~clk;

  lfsr_prbs_checker dut (
    .Clock(clk), .Reset(Reset), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid),
    .Clear_Count(Clear_Count), .Locked(locked), .Error_Pulse(pulse),
    .Error_Count(ecnt), .Bit_Count(bcnt)
  );

  lfsr_prbs_checker #(.Count_Width(4)) dut4 (
    .Clock(clk), .Reset(Reset), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid),
    .Clear_Count(Clear_Count), .Locked(locked4), .Error_Pulse(pulse4),
    .Error_Count(ecnt4), .Bit_Count(bcnt4)
  );

  function automatic string kname(input logic [3:0] k);
    case (k)
      KLock:   return "Locked";
      KPNow:   return "Error_Pulse";
      KPTot:   return "pulse_total";
      KEcnt:   return "Error_Count";
      KBcnt:   return "Bit_Count";
      KEcnt4:  return "Error_Count(w4)";
      KBcnt4:  return "Bit_Count(w4)";
      default: return "Locked(w4)";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [3:0] k);
    case (k)
      KLock:   return {31'b0, locked};
      KPNow:   return {31'b0, pulse};
      KPTot:   return pulse_total;
      KEcnt:   return {16'b0, ecnt};
      KBcnt:   return {16'b0, bcnt};
      KEcnt4:  return {28'b0, ecnt4};
      KBcnt4:  return {28'b0, bcnt4};
      default: return {31'b0, locked4};
    endcase
  endfunction

  // Monitor: expectations queued before an edge are checked after that edge.
  initial begin
    int          n;
    exp_t        it;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      n = exp_q.size();
      @(negedge clk);
      if (pulse === 1'b1) pulse_total++;
      for (int i = 0; i < n; i++) begin
        it  = exp_q.pop_front();
        act = actual(it.kind);
        checks++;
        if (act !== it.val) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d at %0t", kname(it.kind), act, it.val, $time);
        end
      end
    end
  end

  task automatic chk(input logic [3:0] k, input int v);
    exp_q.push_back('{kind: k, val: v});
  endtask

  task automatic drive(input logic v, input logic b, input logic clr);
    Bit_Valid   = v;
    Bit_In      = b;
    Clear_Count = clr;
    @(posedge clk);
    #1;
    Bit_Valid   = 1'b0;
    Clear_Count = 1'b0;
  endtask

  // Generator model: s[n] = s[n-8] ^ XOR(tap[j] & s[n-j]).
  task automatic gen_bit(input logic flip, input logic clr);
    logic       p;
    logic [7:0] t;
    t  = TAPS;
    p  = gh[7] ^ (^(gh[6:0] & t[7:1]));
    gh = {gh[6:0], p};
    drive(1'b1, p ^ flip, clr);
  endtask

  task automatic do_reset();
    chk(KLock, 0); chk(KPNow, 0); chk(KEcnt, 0); chk(KBcnt, 0);
    chk(KEcnt4, 0); chk(KBcnt4, 0);
    Reset = 1'b1;
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    Reset = 1'b0;
    gh = SEED;
  endtask

  task automatic lock_up();
    for (int i = 1; i <= 24; i++) begin
      if (i == 23) chk(KLock, 0);
      if (i == 24) begin chk(KLock, 1); chk(KBcnt, 0); chk(KEcnt, 0); end
      gen_bit(1'b0, 1'b0);
    end
  endtask

  initial begin
    int nv;
    Reset = 1'b1; Bit_Valid = 1'b0; Bit_In = 1'b0; Clear_Count = 1'b0; gh = SEED;
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;

    // Reset mid-operation after some random traffic.
    for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();

    // Clean lock at 24 bits, then 1000 bits in total.
    lock_up();
    for (int i = 0; i < 975; i++) gen_bit(1'b0, 1'b0);
    chk(KEcnt, 0); chk(KBcnt, 976); chk(KPTot, 0);
    gen_bit(1'b0, 1'b0);

    // Single error while locked.
    chk(KPNow, 1); chk(KPTot, 1); chk(KEcnt, 1); chk(KLock, 1);
    gen_bit(1'b1, 1'b0);
    chk(KPNow, 0);
    gen_bit(1'b0, 1'b0);
    for (int i = 0; i < 39; i++) gen_bit(1'b0, 1'b0);
    chk(KEcnt, 1); chk(KLock, 1); chk(KPTot, 1); chk(KBcnt, 1018);
    gen_bit(1'b0, 1'b0);

    // Burst: clear counters, then 4 errors within 8 bits.
    for (int i = 0; i < 5; i++) gen_bit(1'b0, 1'b0);
    chk(KEcnt, 0); chk(KBcnt, 0);
    gen_bit(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) begin chk(KLock, 1); chk(KEcnt, 3); end
      if (k == 8) begin
        chk(KLock, 0); chk(KEcnt, 4); chk(KBcnt, 8); chk(KPNow, 1); chk(KPTot, 5);
      end
      gen_bit(k % 2 == 0, 1'b0);
    end
    for (int i = 1; i <= 24; i++) begin
      if (i == 23) chk(KLock, 0);
      if (i == 24) begin chk(KLock, 1); chk(KEcnt, 4); chk(KBcnt, 8); end
      gen_bit(1'b0, 1'b0);
    end

    // Gaps in Bit_Valid: still 24 valid bits to lock.
    do_reset();
    nv = 0;
    while (nv < 24) begin
      if ($urandom_range(0, 1) == 1) begin
        nv++;
        if (nv == 23) chk(KLock, 0);
        if (nv == 24) begin chk(KLock, 1); chk(KBcnt, 0); end
        gen_bit(1'b0, 1'b0);
      end else begin
        chk(KPNow, 0);
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk(KLock, 1); chk(KBcnt, 0); chk(KPNow, 0);
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // All-zero stream never locks.
    do_reset();
    for (int i = 1; i <= 500; i++) begin
      if (i % 50 == 0) chk(KLock, 0);
      if (i == 500) chk(KBcnt, 0);
      drive(1'b1, 1'b0, 1'b0);
    end

    // Clear colliding with an error, then saturation of the 4-bit counters.
    do_reset();
    lock_up();
    for (int i = 0; i < 10; i++) gen_bit(1'b0, 1'b0);
    chk(KEcnt, 0); chk(KEcnt4, 0); chk(KPNow, 1); chk(KPTot, 6);
    gen_bit(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) gen_bit(1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      if (e == 15) chk(KEcnt4, 15);
      if (e == 20) begin
        chk(KEcnt4, 15); chk(KBcnt4, 15); chk(KLock4, 1);
        chk(KEcnt, 20); chk(KBcnt, 320); chk(KLock, 1); chk(KPTot, 26);
      end
      gen_bit(1'b1, 1'b0);
      for (int i = 0; i < 15; i++) gen_bit(1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ecnt4 !== 4'd15) begin
      errors++;
      $display("FAIL final Error_Count(w4): got %0d expected 15", ecnt4);
    end
    checks++;
    if (locked4 !== 1'b1) begin
      errors++;
      $display("FAIL final Locked(w4): got %0d expected 1", locked4);
    end
    checks++;
    if (ecnt !== 16'd20) begin
      errors++;
      $display("FAIL final Error_Count: got %0d expected 20", ecnt);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL final Locked: got %0d expected 1", locked);
    end
    checks++;
    if (pulse_total != 26) begin
      errors++;
      $display("FAIL final pulse_total: got %0d expected 26", pulse_total);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Serial PRBS checker for the bit stream produced by our modular (Galois) LFSR generators; it sits on the receive side of a test link. It self-synchronises to the incoming stream from its polynomial alone, with no seed exchange. It then flywheels a local prediction, counts bit errors and declares loss of lock on error bursts. The polynomial parameters match the generator's, so one `Length`/`Tap_Coefficient` pair configures both ends.

## Interface
- `Length`, 8: LFSR order, at least 3.
- `Tap_Coefficient`, 8'b1111_0011: same encoding as the generator. Bits `[Length-1:1]` are used; bit 0 is ignored because the `x^0` term is implicit.
- `Lock_Count`, 16: consecutive correct predictions required to lock.
- `Window_Bits`, 32: loss-of-lock observation window, in valid bits.
- `Loss_Errors`, 4: errors inside one window that force loss of lock.
- `Count_Width`, 16: width of the error and bit counters.

Ports:
- `Clock`  in  1  single clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Bit_In`  in  1  received serial bit, equal to generator output `Y[Length]`.
- `Bit_Valid`  in  1  `Bit_In` is sampled only when this is high.
- `Clear_Count`  in  1  synchronous clear of `Error_Count` and `Bit_Count`.
- `Locked`  out  1  checker is synchronised.
- `Error_Pulse`  out  1  one-cycle strobe for a mismatched bit while locked.
- `Error_Count`  out  `Count_Width`  saturating count of errors while locked.
- `Bit_Count`  out  `Count_Width`  saturating count of bits checked while locked.

## Operation
- **Recurrence.** The generator output `s` satisfies `s[n] = s[n-Length] ^ XOR_{j=1..Length-1}(Tap_Coefficient[j] & s[n-j])`.
- **History and prediction.**
  - `H[1..Length]` is a history register holding `s[n-1]..s[n-Length]`.
  - `P` is the prediction for `s[n]`, computed combinationally from `H`.
- **FSM states.** `SEARCH`, `LOCKED`. Reset leaves the FSM in `SEARCH` with `H` = 0, fill count = 0 and match count = 0.
- **SEARCH**, on each valid bit:
  - `H` shifts in `Bit_In`.
  - While fill count < `Length`, only the fill count increments.
  - Once full:
    - If `Bit_In == P` and the pre-shift `H` ≠ 0, the match count increments.
    - Otherwise the match count is cleared.
    - An all-zero `H` therefore never locks.
  - When the match count reaches `Lock_Count`, go to `LOCKED` and clear the window and burst counters.
  - No errors are counted in `SEARCH`.
- **LOCKED**, on each valid bit:
  - `H` shifts in `P`, not `Bit_In` (flywheel), so one channel error yields exactly one error.
  - `Bit_Count` increments.
  - On `Bit_In != P`: pulse `Error_Pulse`, increment `Error_Count` and increment the burst counter.
  - The window counter increments. When it reaches `Window_Bits`, both the window counter and the burst counter clear.
  - When the burst counter reaches `Loss_Errors`, go to `SEARCH` with fill count and match count = 0. `Error_Count` and `Bit_Count` are retained.
- **Counters.** Both counters saturate at all-ones and never wrap. `Clear_Count` has priority over an increment in the same cycle; the result is 0.
- **Invalid cycles.** `Bit_Valid` low leaves all state unchanged and forces `Error_Pulse` to 0.

## Timing
- All outputs are registered.
- Reset values: `Locked` = 0, `Error_Pulse` = 0, `Error_Count` = 0, `Bit_Count` = 0.
- Reset asserted mid-operation overrides everything on that edge.
- Lock latency: `Locked` rises on the edge that samples valid bit number `Length + Lock_Count`, counted from reset or from loss of lock.
- `Error_Pulse`, the counter updates and `Locked` falling are all visible in the cycle after the edge sampling the offending bit.
- On the valid bit that completes lock, that bit counts as a match and is not itself checked or counted in `Bit_Count`.
- Back-to-back valid bits are supported at full rate; there is no stall or backpressure.

## Test plan
1. **Reset.** Drive random `Bit_In` with `Bit_Valid` = 1, then assert `Reset` for 1 cycle. All outputs are 0 on the following cycle, and `Locked` stays 0 for the next 23 valid bits.
2. **Clean lock, default parameters.** Feed the output of a generator model (initial state 8'b1001_0001, taps 8'b1111_0011). `Locked` rises after exactly 24 valid bits. After 1000 total bits: `Error_Count` = 0 and `Bit_Count` = 976.
3. **Single error while locked.** Flip one bit. Exactly one `Error_Pulse`, `Error_Count` = 1, and `Locked` stays 1.
4. **Burst.** Flip 4 bits within 32 bits. `Locked` falls the cycle after the 4th error. Clean bits relock after 24 further bits, with `Error_Count` retained at 4.
5. **Gaps and all-zero input.**
   - Randomly deassert `Bit_Valid` (~50%). Lock still occurs at exactly 24 valid bits.
   - An all-zero stream of 500 bits never locks.
6. **Clear collision and saturation.**
   - Assert `Clear_Count` in the same cycle as an error. `Error_Count` = 0 afterward.
   - With `Count_Width` = 4, 20 errors leave `Error_Count` = 15.
